aes_cipher_seq: RTL and testbench



---
 rtl/aes_seq_pkg.sv | 73 +++++++
 rtl/aes_round.sv | 64 ++++++
 rtl/aes_cipher_seq.sv | 116 +++++++++++
 tb/tb_aes_cipher_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// ============================================================================
// Module      : aes_seq_pkg
// Description : Shared types, FSM encoding, S-box, xtime and rcon table for
//               the iterative AES-128 cipher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_seq_pkg;

  typedef logic [7:0] byte_t;
  // blk[i][j] is FIPS-197 byte 4*i+j (i = column, j = row)
  typedef byte_t [0:3][0:3] blk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // Indexed directly by the round counter; entries 0 and 11..15 are unused
  localparam byte_t RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t sbox(input byte_t b);
    byte_t s;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round.sv
// ============================================================================
// Module      : aes_round
// Description : One combinational AES-128 round with on-the-fly key expansion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round
  import aes_seq_pkg::*;
(
  input  blk_t  st_i,
  input  blk_t  rk_i,
  input  byte_t rcon_i,
  input  logic  last_i,
  output blk_t  st_o,
  output blk_t  rk_o
);

  blk_t        sb;
  blk_t        sr;
  blk_t        mc;
  blk_t        nk;
  byte_t [0:3] tw;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[c][r] = sbox(st_i[c][r]);
      end
    end
    // Row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[c][r] = sb[(c + r) % 4][r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[c][0] = xtime(sr[c][0]) ^ xtime(sr[c][1]) ^ sr[c][1] ^ sr[c][2] ^ sr[c][3];
      mc[c][1] = sr[c][0] ^ xtime(sr[c][1]) ^ xtime(sr[c][2]) ^ sr[c][2] ^ sr[c][3];
      mc[c][2] = sr[c][0] ^ sr[c][1] ^ xtime(sr[c][2]) ^ xtime(sr[c][3]) ^ sr[c][3];
      mc[c][3] = xtime(sr[c][0]) ^ sr[c][0] ^ sr[c][1] ^ sr[c][2] ^ xtime(sr[c][3]);
    end
  end

  // SubWord(RotWord(w3)) ^ rcon, then the running XOR across the four words
  always_comb begin
    tw[0] = sbox(rk_i[3][1]) ^ rcon_i;
    tw[1] = sbox(rk_i[3][2]);
    tw[2] = sbox(rk_i[3][3]);
    tw[3] = sbox(rk_i[3][0]);
    for (int r = 0; r < 4; r++) begin
      nk[0][r] = rk_i[0][r] ^ tw[r];
      nk[1][r] = rk_i[1][r] ^ rk_i[0][r] ^ tw[r];
      nk[2][r] = rk_i[2][r] ^ rk_i[1][r] ^ rk_i[0][r] ^ tw[r];
      nk[3][r] = rk_i[3][r] ^ rk_i[2][r] ^ rk_i[1][r] ^ rk_i[0][r] ^ tw[r];
    end
  end

  assign st_o = (last_i ? sr : mc) ^ nk;
  assign rk_o = nk;

endmodule

`default_nettype wire

// File: rtl/aes_cipher_seq.sv
// ============================================================================
// Module      : aes_cipher_seq
// Description : Iterative AES-128 encryption controller with valid/ready I/O.
//               AES_SEQ_DOUBLE_ROUND_EN chains two rounds per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cipher_seq
  import aes_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  blk_t key,
  input  blk_t data,
  output logic out_valid,
  input  logic out_ready,
  output blk_t o
);

  state_t     state_q, state_d;
  blk_t       st_q, st_d;
  blk_t       rk_q, rk_d;
  blk_t       o_q, o_d;
  logic [3:0] rnd_q, rnd_d;
  blk_t       rnd_st, rnd_rk;
  logic       rnd_ok;
  logic       rnd_last;

`ifdef AES_SEQ_DOUBLE_ROUND_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  localparam logic [3:0] LAST_RND = 4'd9;
  blk_t       mid_st, mid_rk;
  logic [3:0] rnd_b;

  assign rnd_b  = rnd_q + 4'd1;
  assign rnd_ok = rnd_q[0] && (rnd_q <= LAST_RND);

  aes_round u_round_a (
    .st_i(st_q), .rk_i(rk_q), .rcon_i(RCON[rnd_q]), .last_i(1'b0),
    .st_o(mid_st), .rk_o(mid_rk)
  );
  aes_round u_round_b (
    .st_i(mid_st), .rk_i(mid_rk), .rcon_i(RCON[rnd_b]), .last_i(rnd_b == NUM_ROUNDS),
    .st_o(rnd_st), .rk_o(rnd_rk)
  );
`else
  localparam logic [3:0] RND_STEP = 4'd1;
  localparam logic [3:0] LAST_RND = NUM_ROUNDS;

  assign rnd_ok = (rnd_q != 4'd0) && (rnd_q <= NUM_ROUNDS);

  aes_round u_round (
    .st_i(st_q), .rk_i(rk_q), .rcon_i(RCON[rnd_q]), .last_i(rnd_q == NUM_ROUNDS),
    .st_o(rnd_st), .rk_o(rnd_rk)
  );
`endif

  assign rnd_last = (rnd_q == LAST_RND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      o_q     <= '0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      o_q     <= o_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (!rnd_ok) state_d = IDLE;
               else if (rnd_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    rk_d  = rk_q;
    o_d   = o_q;
    rnd_d = rnd_q;
    if (state_q == IDLE && in_valid) begin
      st_d  = data ^ key;
      rk_d  = key;
      rnd_d = 4'd1;
    end else if (state_q == RUN && rnd_ok) begin
      st_d  = rnd_st;
      rk_d  = rnd_rk;
      rnd_d = rnd_q + RND_STEP;
      if (rnd_last) o_d = rnd_st;
    end
  end

  // in_ready is held low while reset is asserted even though the FSM sits in IDLE
  always_comb begin
    in_ready  = (state_q == IDLE) && rst;
    out_valid = (state_q == DONE);
    o         = o_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_cipher_seq.sv
// ============================================================================
// Module      : tb_aes_cipher_seq
// Description : Self-checking bench for aes_cipher_seq against a FIPS-197
//               reference model (S-box derived from GF(2^8) inversion).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_cipher_seq;

`ifdef AES_SEQ_DOUBLE_ROUND_EN
  localparam int LAT    = 5;
  localparam int RST_AT = 2;
`else
  localparam int LAT    = 10;
  localparam int RST_AT = 4;
`endif
  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_O = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_D  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_O  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key_s = '0;
  logic [127:0] data_s = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] o_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] bk [3];
  logic [127:0] bd [3];
  logic [127:0] be [3];
  int           acc_t [3];
  int           acc, ia, io, nb;
  bit           acc_now, out_now;
  logic [127:0] k2, d2, e1, e2;

  aes_cipher_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key_s), .data(data_s), .out_valid(out_valid), .out_ready(out_ready), .o(o_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp = '{sbox_m[w[i-3]] ^ rc, sbox_m[w[i-2]], sbox_m[w[i-1]], sbox_m[w[i-4]]};
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int n = 0; n < 16; n++) s[n] = d[127-8*n -: 8] ^ w[n];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox_m[s[n]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[16*rd+n];
    end
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] d, output int acc_c);
    int n;
    n = 0;
    key_s = k; data_s = d; in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("accept ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    acc_c = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int acc_c, input logic [127:0] exp, input bit scramble);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      if (scramble) begin key_s = rnd128(); data_s = rnd128(); end
      @(posedge clk); #1; n++;
    end
    check({tag, " out_valid"}, 128'(out_valid), 128'd1);
    check({tag, " latency"}, 128'(cyc - acc_c), 128'(LAT));
    check({tag, " ciphertext"}, o_s, exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 128'(out_valid), 128'd0);
    check({tag, " in_ready back"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    // Reset values
    @(posedge clk); #1;
    check("reset in_ready", 128'(in_ready), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset o", o_s, 128'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", 128'(in_ready), 128'd1);

    // Known-answer vectors
    send(C1_K, C1_D, acc);
    wait_out("C1", acc, C1_O, 1'b0);
    consume("C1");
    send(B_K, B_D, acc);
    wait_out("AppB", acc, B_O, 1'b0);
    consume("AppB");

    // Random blocks against the model
    for (int i = 0; i < 3; i++) begin
      k2 = rnd128(); d2 = rnd128();
      send(k2, d2, acc);
      wait_out("random", acc, aes_ref(k2, d2), 1'b0);
      consume("random");
    end

    // Inputs change every cycle while the block is in flight
    send(C1_K, C1_D, acc);
    wait_out("stability", acc, C1_O, 1'b1);
    consume("stability");

    // Backpressure with a pending second block
    k2 = rnd128(); d2 = rnd128(); e1 = aes_ref(k2, d2);
    send(k2, d2, acc);
    wait_out("bp first", acc, e1, 1'b0);
    k2 = rnd128(); d2 = rnd128(); e2 = aes_ref(k2, d2);
    key_s = k2; data_s = d2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp o stable", o_s, e1);
      check("bp out_valid held", 128'(out_valid), 128'd1);
      check("bp in_ready low", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    consume("bp");
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    check("bp second accepted", 128'(in_ready), 128'd0);
    wait_out("bp second", acc, e2, 1'b0);
    consume("bp second");

    // Reset in the middle of a block
    send(rnd128(), rnd128(), acc);
    repeat (RST_AT) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst o", o_s, 128'd0);
    check("midrst in_ready", 128'(in_ready), 128'd0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("midrst no output", 128'(out_valid), 128'd0);
    end
    check("midrst idle", 128'(in_ready), 128'd1);

    // Back-to-back blocks with both handshakes held high
    for (int i = 0; i < 3; i++) begin
      bk[i] = rnd128(); bd[i] = rnd128(); be[i] = aes_ref(bk[i], bd[i]);
    end
    ia = 0; io = 0; nb = 0;
    key_s = bk[0]; data_s = bd[0]; in_valid = 1'b1; out_ready = 1'b1;
    while ((ia < 3 || io < 3) && nb < 200) begin
      acc_now = in_valid && in_ready;
      out_now = out_valid && out_ready;
      if (out_now && io < 3) check("b2b ciphertext", o_s, be[io]);
      @(posedge clk); #1;
      nb++;
      if (acc_now) begin
        acc_t[ia] = cyc;
        ia++;
        if (ia < 3) begin key_s = bk[ia]; data_s = bd[ia]; end
        else in_valid = 1'b0;
      end
      if (out_now) io++;
    end
    out_ready = 1'b0;
    check("b2b outputs", 128'(io), 128'd3);
    check("b2b spacing 1", 128'(acc_t[1] - acc_t[0]), 128'(LAT + 2));
    check("b2b spacing 2", 128'(acc_t[2] - acc_t[1]), 128'(LAT + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
